// File: rtl/adam_periph_irqc.sv
// APB interrupt controller: per-source enable, level/edge trigger, W1C pending,
// lowest-index claim register and a pause handshake that quiesces the bus and irq.
module adam_periph_irqc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NO_IRQS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic [ADDR_WIDTH-1:0]   apb_paddr,
  input  logic                    apb_psel,
  input  logic                    apb_penable,
  input  logic                    apb_pwrite,
  input  logic [DATA_WIDTH-1:0]   apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0] apb_pstrb,
  output logic [DATA_WIDTH-1:0]   apb_prdata,
  output logic                    apb_pready,
  output logic                    apb_pslverr,
  input  logic [NO_IRQS-1:0]      irq_src,
  output logic                    irq
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                  r_alive, r_cr, r_irq;
  logic [NO_IRQS-1:0]    r_ier, r_tr, r_pr, r_src_q;
  logic                  w_active, w_xfer, w_wr, w_rd;
  logic                  w_hit_cr, w_hit_ier, w_hit_pr, w_hit_tr, w_hit_claim, w_err;
  logic [DATA_WIDTH-1:0] w_bmask, w_wdata_m, w_rdata, w_claim_id;
  logic [NO_IRQS-1:0]    w_pend_en, w_claim_oh, w_set, w_clr;
  logic                  w_unused_bits;

  // r_alive keeps the bus outputs quiet until the first clock after reset release.
  assign w_active = r_alive & (r_state != ST_PAUSED);
  assign w_xfer   = apb_psel & apb_penable & w_active;
  assign w_wr     = w_xfer & apb_pwrite;
  assign w_rd     = w_xfer & ~apb_pwrite;

  assign w_hit_cr    = (apb_paddr[7:0] == 8'h00);
  assign w_hit_ier   = (apb_paddr[7:0] == 8'h04);
  assign w_hit_pr    = (apb_paddr[7:0] == 8'h08);
  assign w_hit_tr    = (apb_paddr[7:0] == 8'h0C);
  assign w_hit_claim = (apb_paddr[7:0] == 8'h10);
  assign w_err       = ~(w_hit_cr | w_hit_ier | w_hit_pr | w_hit_tr | w_hit_claim);

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++) w_bmask[8*b +: 8] = {8{apb_pstrb[b]}};
  end

  assign w_wdata_m = apb_pwdata & w_bmask;
  assign w_pend_en = r_pr & r_ier;

  // Descending scan so the lowest pending-and-enabled index wins.
  always_comb begin
    w_claim_oh = '0;
    w_claim_id = '0;
    for (int i = NO_IRQS-1; i >= 0; i--) begin
      if (w_pend_en[i]) begin
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
        w_claim_id    = DATA_WIDTH'(i + 1);
      end
    end
  end

  assign w_set = (irq_src & ~r_src_q & r_tr) | (irq_src & ~r_tr);
  assign w_clr = ({NO_IRQS{w_wr & w_hit_pr}} & w_wdata_m[NO_IRQS-1:0])
               | ({NO_IRQS{w_rd & w_hit_claim}} & w_claim_oh);

  always_comb begin
    w_rdata = '0;
    if (w_hit_cr)         w_rdata[0]         = r_cr;
    else if (w_hit_ier)   w_rdata[NO_IRQS-1:0] = r_ier;
    else if (w_hit_pr)    w_rdata[NO_IRQS-1:0] = r_pr;
    else if (w_hit_tr)    w_rdata[NO_IRQS-1:0] = r_tr;
    else if (w_hit_claim) w_rdata            = w_claim_id;
  end

  assign apb_prdata  = w_rd ? w_rdata : '0;
  assign apb_pready  = w_active;
  assign apb_pslverr = w_xfer & w_err;
  assign pause_ack   = (r_state == ST_PAUSED);
  assign irq         = r_irq;

  assign w_unused_bits = ^{apb_paddr[ADDR_WIDTH-1:8], w_wdata_m};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // A pause request withdrawn before PAUSED is reached aborts the pause.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (pause_req) w_state_nxt = ST_PAUSING;
      ST_PAUSING: begin
        if (!pause_req)                w_state_nxt = ST_RUN;
        else if (!apb_psel || w_xfer)  w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED:  if (!pause_req) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive <= 1'b0;
      r_cr    <= 1'b0;
      r_ier   <= '0;
      r_tr    <= '0;
      r_pr    <= '0;
      r_src_q <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_src_q <= irq_src;
      r_pr    <= (r_pr & ~w_clr) | w_set;
      r_irq   <= r_cr & (|w_pend_en) & (r_state == ST_RUN);
      if (w_wr && w_hit_cr && apb_pstrb[0]) r_cr <= apb_pwdata[0];
      if (w_wr && w_hit_ier) r_ier <= (r_ier & ~w_bmask[NO_IRQS-1:0]) | w_wdata_m[NO_IRQS-1:0];
      if (w_wr && w_hit_tr)  r_tr  <= (r_tr  & ~w_bmask[NO_IRQS-1:0]) | w_wdata_m[NO_IRQS-1:0];
    end
  end

endmodule

// File: tb/tb_adam_periph_irqc.sv
// Scoreboard bench for adam_periph_irqc: directed scenarios plus a randomized phase
// predicted by a register-level reference model.
module tb_adam_periph_irqc;
  localparam int N = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pause_req = 1'b0;
  logic          pause_ack;
  logic [31:0]   paddr = '0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [N-1:0]  irq_src = '0;
  logic          irq;

  always #5 clk = ~clk;

  adam_periph_irqc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_IRQS(N)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_pstrb(pstrb), .apb_prdata(prdata), .apb_pready(pready),
    .apb_pslverr(pslverr), .irq_src(irq_src), .irq(irq)
  );

  typedef struct { logic is_rd; logic [31:0] data; logic err; string name; } acc_t;
  typedef struct { logic c_irq; logic e_irq; logic c_ack; logic e_ack;
                   logic c_rdy; logic e_rdy; logic c_bus0; string name; } prb_t;

  acc_t acc_q[$];
  prb_t prb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: register contents after each rising edge.
  logic [31:0] m_cr, m_ier, m_tr, m_pr, m_srcq;
  logic        m_irq;

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    return (old & ~bmask(s)) | (d & bmask(s));
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    case (a[7:0])
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10: return 1'b0;
      default:                           return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] claim_id(input logic [31:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[7:0])
      8'h00:   return m_cr;
      8'h04:   return m_ier;
      8'h08:   return m_pr;
      8'h0C:   return m_tr;
      8'h10:   return claim_id(m_pr & m_ier);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_clr(input logic acc, input logic wr, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s,
                                            input logic [31:0] pend);
    logic [31:0] id;
    if (!acc) return 32'd0;
    if (wr && a[7:0] == 8'h08) return d & bmask(s) & MASK;
    id = claim_id(pend);
    if (!wr && a[7:0] == 8'h10 && id != 0) return 32'd1 << (id - 1);
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_set(input logic [31:0] src, input logic [31:0] srcq, input logic [31:0] tr);
    return ((src & ~srcq & tr) | (src & ~tr)) & MASK;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cr <= '0; m_ier <= '0; m_tr <= '0; m_pr <= '0; m_srcq <= '0; m_irq <= 1'b0;
    end else begin
      if (psel && penable && pwrite) begin
        case (paddr[7:0])
          8'h00:   m_cr  <= merge(m_cr, pwdata, pstrb) & 32'h1;
          8'h04:   m_ier <= merge(m_ier, pwdata, pstrb) & MASK;
          8'h0C:   m_tr  <= merge(m_tr, pwdata, pstrb) & MASK;
          default: ;
        endcase
      end
      m_pr   <= (m_pr & ~model_clr(psel && penable, pwrite, paddr, pwdata, pstrb, m_pr & m_ier))
              | model_set(32'(irq_src), m_srcq, m_tr);
      m_srcq <= 32'(irq_src);
      m_irq  <= m_cr[0] && ((m_pr & m_ier) != 0);
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // Monitor: evaluates queued probes, then any access phase in progress.
  always @(negedge clk) begin
    prb_t p;
    acc_t a;
    while (prb_q.size() > 0) begin
      p = prb_q.pop_front();
      if (p.c_irq) chk({p.name, ".irq"}, 32'(irq), 32'(p.e_irq));
      if (p.c_ack) chk({p.name, ".pause_ack"}, 32'(pause_ack), 32'(p.e_ack));
      if (p.c_rdy) chk({p.name, ".pready"}, 32'(pready), 32'(p.e_rdy));
      if (p.c_bus0) begin
        chk({p.name, ".prdata"}, prdata, 32'd0);
        chk({p.name, ".pslverr"}, 32'(pslverr), 32'd0);
      end
    end
    if (!rst) acc_q.delete();
    else if (psel && penable) begin
      if (acc_q.size() == 0) chk("unexpected_access", 32'(acc_q.size()), 32'd1);
      else begin
        a = acc_q.pop_front();
        chk({a.name, ".pready"}, 32'(pready), 32'd1);
        if (a.is_rd) chk({a.name, ".prdata"}, prdata, a.data);
        chk({a.name, ".pslverr"}, 32'(pslverr), 32'(a.err));
      end
    end
  end

  task automatic probe(input logic ci, input logic ei, input logic ca, input logic ea,
                       input logic cr, input logic er, input logic cb, input string nm);
    prb_t p;
    p.c_irq = ci; p.e_irq = ei; p.c_ack = ca; p.e_ack = ea;
    p.c_rdy = cr; p.e_rdy = er; p.c_bus0 = cb; p.name = nm;
    prb_q.push_back(p);
  endtask

  task automatic pirq(input logic e, input string nm);
    probe(1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic use_model, input logic [31:0] exp_d, input string nm);
    acc_t e;
    cyc(); psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    cyc(); penable = 1'b1;
    e.is_rd = !wr; e.data = use_model ? model_rd(a) : exp_d; e.err = is_err(a); e.name = nm;
    acc_q.push_back(e);
    cyc(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    xfer(1'b1, a, d, 4'hF, 1'b0, 32'd0, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input string nm);
    xfer(1'b0, a, 32'd0, 4'h0, 1'b0, exp_d, nm);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    cyc(); irq_src = irq_src | m;
    cyc(); irq_src = irq_src & ~m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int off_tab[7];
    logic [31:0] a;
    int op;
    off_tab = '{0, 4, 8, 12, 16, 20, 32};

    // Reset state
    cyc(); cyc();
    probe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "in_reset");
    cyc(); rst = 1'b1;
    rd(32'h00, 32'd0, "rst_cr"); rd(32'h04, 32'd0, "rst_ier");
    rd(32'h08, 32'd0, "rst_pr"); rd(32'h0C, 32'd0, "rst_tr");

    // Edge mode, single source
    wr(32'h00, 32'h1, "w_cr"); wr(32'h04, 32'h1, "w_ier"); wr(32'h0C, 32'h1, "w_tr");
    pulse(8'h01);
    pirq(1'b0, "edge_irq_lag");
    cyc(); pirq(1'b1, "edge_irq");
    rd(32'h08, 32'h1, "edge_pr");
    rd(32'h10, 32'd1, "edge_claim");
    rd(32'h08, 32'h0, "edge_pr_after");
    pirq(1'b0, "edge_irq_after");

    // Priority
    wr(32'h0C, 32'hFF, "w_tr_all"); wr(32'h04, 32'hFF, "w_ier_all");
    pulse(8'h24);
    rd(32'h10, 32'd3, "prio_claim3"); rd(32'h10, 32'd6, "prio_claim6"); rd(32'h10, 32'd0, "prio_claim0");

    // Level mode
    wr(32'h0C, 32'h0, "w_tr_lvl");
    cyc(); irq_src[1] = 1'b1;
    rd(32'h08, 32'h2, "lvl_pr");
    wr(32'h08, 32'h2, "lvl_w1c_hi");
    rd(32'h08, 32'h2, "lvl_pr_stays");
    cyc(); irq_src[1] = 1'b0;
    wr(32'h08, 32'h2, "lvl_w1c_lo");
    rd(32'h08, 32'h0, "lvl_pr_clear");

    // Masking
    wr(32'h04, 32'h0, "w_ier_off"); wr(32'h0C, 32'hFF, "w_tr_edge");
    pulse(8'h08);
    rd(32'h08, 32'h8, "mask_pr");
    pirq(1'b0, "mask_irq_off");
    rd(32'h10, 32'd0, "mask_claim0");
    wr(32'h04, 32'h8, "w_ier_8");
    cyc(); pirq(1'b1, "mask_irq_on");
    rd(32'h10, 32'd4, "mask_claim4");
    cyc(); pirq(1'b0, "mask_irq_clear");

    // Pause during a write
    wr(32'h04, 32'h11, "w_ier_11"); wr(32'h0C, 32'h01, "w_tr_01");
    cyc(); irq_src[4] = 1'b1;
    cyc(); cyc(); pirq(1'b1, "pre_pause_irq");
    cyc(); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1; pstrb = 4'hF;
    cyc(); penable = 1'b1; pause_req = 1'b1;
    acc_q.push_back('{is_rd: 1'b0, data: 32'd0, err: 1'b0, name: "pause_write"});
    cyc(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    probe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pausing");
    cyc(); probe(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "paused");
    pulse(8'h01);
    probe(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "paused_after_edge");
    cyc(); pause_req = 1'b0;
    cyc(); probe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "resume");
    cyc(); pirq(1'b1, "resume_irq");
    rd(32'h08, 32'h11, "pause_pr");
    rd(32'h10, 32'd1, "pause_claim1");
    cyc(); irq_src[4] = 1'b0;
    rd(32'h10, 32'd5, "pause_claim5");
    rd(32'h08, 32'h0, "pause_pr_clear");

    // Aborted pause
    cyc(); pause_req = 1'b1;
    cyc(); pause_req = 1'b0;
    probe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort_pausing");
    cyc(); probe(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "abort_run");
    rd(32'h00, 32'h1, "abort_cr");

    // Errors, strobes, unused bits
    wr(32'h20, 32'hFFFF_FFFF, "err_w20");
    rd(32'h20, 32'h0, "err_r20");
    wr(32'h14, 32'h0, "err_w14");
    rd(32'h00, 32'h1, "err_cr_kept");
    xfer(1'b1, 32'h04, 32'h0000_00AA, 4'h0, 1'b0, 32'd0, "strb_none");
    rd(32'h04, 32'h11, "strb_none_ier");
    xfer(1'b1, 32'h04, 32'hFFFF_FF22, 4'hE, 1'b0, 32'd0, "strb_hi");
    rd(32'h04, 32'h11, "strb_hi_ier");
    xfer(1'b1, 32'h04, 32'h0000_0022, 4'h1, 1'b0, 32'd0, "strb_lo");
    rd(32'h04, 32'h22, "strb_lo_ier");
    wr(32'h00, 32'hFFFF_FFFF, "w_cr_ones");
    rd(32'h00, 32'h1, "cr_hi_zero");
    wr(32'h04, 32'hFFFF_FFFF, "w_ier_ones");
    rd(32'h04, 32'hFF, "ier_hi_zero");

    // Reset during an access phase
    wr(32'h0C, 32'h5A, "w_tr_pre_rst");
    cyc(); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5; pstrb = 4'hF;
    cyc(); penable = 1'b1;
    acc_q.push_back('{is_rd: 1'b0, data: 32'd0, err: 1'b0, name: "rst_mid"});
    #2 rst = 1'b0;
    probe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "rst_mid_outputs");
    cyc(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cyc(); rst = 1'b1;
    rd(32'h00, 32'd0, "post_rst_cr"); rd(32'h04, 32'd0, "post_rst_ier");
    rd(32'h0C, 32'd0, "post_rst_tr"); rd(32'h08, 32'd0, "post_rst_pr");
    rd(32'h10, 32'd0, "post_rst_claim");

    // Randomized traffic against the reference model
    wr(32'h00, 32'h1, "rnd_cr_on");
    for (int it = 0; it < 150; it++) begin
      cyc();
      if ($urandom_range(0, 2) == 0) irq_src = N'($urandom);
      pirq(m_irq, "rnd_irq");
      op = $urandom_range(0, 9);
      a = $urandom;
      if (op <= 3) begin
        a[7:0] = 8'(off_tab[$urandom_range(0, 6)]);
        xfer(1'b0, a, 32'd0, 4'h0, 1'b1, 32'd0, "rnd_rd");
      end else if (op <= 7) begin
        a[7:0] = 8'(off_tab[$urandom_range(0, 3)]);
        xfer(1'b1, a, $urandom, 4'($urandom), 1'b1, 32'd0, "rnd_wr");
      end else if (op == 8) begin
        a[7:0] = 8'(off_tab[$urandom_range(5, 6)]);
        xfer(1'b1, a, $urandom, 4'hF, 1'b1, 32'd0, "rnd_wr_err");
      end
    end

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adam_periph_irqc.md
ADAM_PERIPH_IRQC -- requirements
Module: adam_periph_irqc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width; only 32 is supported.
REQ-003 SHALL have parameter NO_IRQS, default 8: number of interrupt sources, legal range 1..32.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port pause_req, input, 1 bit: pause request.
REQ-007 SHALL have port pause_ack, output, 1 bit: pause acknowledge.
REQ-008 SHALL have port apb, APB slave interface, ADDR_WIDTH/DATA_WIDTH: register access.
REQ-009 SHALL have port irq_src, input, NO_IRQS bits: peripheral interrupt lines, e.g. timer irq on bit 0.
REQ-010 SHALL have port irq, output, 1 bit: aggregated interrupt to the core.

Function
REQ-011 SHALL decode registers on addr[7:0]: 0x00 CR, 0x04 IER, 0x08 PR, 0x0C TR, 0x10 CLAIM; any other offset gives pslverr=1, no side effect, prdata=0.
REQ-012 SHALL define CR bit0 as global enable (RW); bits 31:1 read 0.
REQ-013 SHALL define IER as per-source enable (RW); bits at NO_IRQS and above read 0 and ignore writes.
REQ-014 SHALL define TR as per-source trigger mode (RW): 0 = level, 1 = rising edge.
REQ-015 SHALL define PR as the pending bits; reads return them; a write clears each pending bit whose pwdata bit is 1 (W1C).
REQ-016 SHALL define CLAIM as read-only: it returns (lowest index i with PR[i]&IER[i]) + 1, or 0 if none, and in the same cycle clears that PR bit; writes are ignored with pslverr=0.
REQ-017 SHALL apply pstrb per byte lane on CR, IER, TR and PR writes.
REQ-018 SHALL complete every APB access with zero wait states (pready=1 in the access phase) while in state RUN.
REQ-019 SHALL register irq_src into src_q each cycle; an edge is irq_src[i]=1 and src_q[i]=0.
REQ-020 SHALL, in edge mode, set PR[i] at the clock edge where the edge is sampled.
REQ-021 SHALL, in level mode, set PR[i] on every cycle irq_src[i]=1; a W1C or claim then has no lasting effect while the source stays high.
REQ-022 SHALL capture sources regardless of IER, CR and pause state; IER masks only irq and CLAIM.
REQ-023 SHALL let set win over clear when a W1C or claim and a set hit the same bit in the same cycle.
REQ-024 SHALL register irq = CR[0] & |(PR & IER) & (state==RUN); an edge-mode source edge sampled at edge N gives PR at N and irq at N+1.
REQ-025 SHALL use pause state machine RUN -> PAUSING -> PAUSED -> RUN.
REQ-026 SHALL go RUN -> PAUSING when pause_req=1; an APB access phase already in progress completes in that cycle.
REQ-027 SHALL go PAUSING -> PAUSED on the next cycle with psel=0 or a completed transfer; pause_ack=1 in PAUSED.
REQ-028 SHALL hold pready=0, irq=0 and all registers except PR and src_q in PAUSED.
REQ-029 SHALL go PAUSED -> RUN one cycle after pause_req=0, with pause_ack=0 from that same edge.
REQ-030 SHALL drop a pause_req pulse that deasserts during PAUSING back to RUN without asserting pause_ack.

Reset
REQ-031 SHALL, while rst=0, immediately force CR, IER, TR, PR and src_q to 0, irq=0, pause_ack=0, state=RUN, pready=0, pslverr=0, prdata=0.
REQ-032 SHALL discard an APB transfer in flight when reset asserts mid-operation; after rst rises the first access completes normally.

Verification
REQ-033 SHALL cover edge mode: CR=1, IER=1, TR=1, pulse irq_src[0] for 1 cycle -> PR=0x1, irq high one cycle later; CLAIM read returns 1, then PR=0 and irq falls.
REQ-034 SHALL cover priority: sources 2 and 5 edge-pending and enabled -> CLAIM returns 3, then 6, then 0.
REQ-035 SHALL cover level mode: TR=0, irq_src[1] held high, W1C PR=0x2 -> PR[1] stays 1; source low, then W1C -> PR=0.
REQ-036 SHALL cover masking: IER=0, edge on source 3 -> PR=0x8, irq=0, CLAIM=0; set IER=0x8 -> irq=1.
REQ-037 SHALL cover pause: pause_req raised during a write -> write completes, pause_ack=1, irq=0, an edge on source 0 still sets PR; pause_req low -> pause_ack=0, irq returns.
REQ-038 SHALL cover errors and reset: access to offset 0x20 -> pslverr=1; rst=0 mid-access -> all registers read 0 after release.
